// File: rtl/hram_arbiter.sv
// Two-master front end for a single HyperRAM controller: instruction fetch (m0, read-only)
// and data port (m1, read/write), one transaction in flight, m1 favoured with an anti-starvation guard for m0.
module hram_arbiter #(
    parameter int AW     = 24,
    parameter int DW     = 32,
    parameter int STARVE = 3
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic [3:0]    m0_len,
    output logic          m0_ack,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          m0_done,

    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [3:0]    m1_len,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_wready,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          m1_done,

    output logic          c_req,
    output logic          c_we,
    output logic [AW-1:0] c_addr,
    output logic [3:0]    c_len,
    output logic [DW-1:0] c_wdata,
    input  logic          c_gnt,
    input  logic          c_wready,
    input  logic          c_rvalid,
    input  logic [DW-1:0] c_rdata,
    input  logic          c_done,

    output logic          beat_err
);

    localparam int SW = (STARVE < 1) ? 1 : $clog2(STARVE + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t          state_reg;
    logic            owner_reg;     // 0 = m0, 1 = m1
    logic [AW-1:0]   addr_reg;
    logic [3:0]      len_reg;
    logic            we_reg;
    logic            c_req_reg;
    logic [SW-1:0]   starve_reg;
    logic [4:0]      beat_reg;
    logic            beat_err_reg;

    logic            starved;
    logic            pick_m1;
    logic            beat_now;
    logic [4:0]      beat_total;
    logic [4:0]      beat_want;
    logic            in_grant;
    logic            in_xfer;
    logic            own0_xfer;
    logic            own1_xfer;

    assign starved    = (starve_reg == SW'(STARVE));
    assign pick_m1    = m1_req && !(m0_req && starved);
    assign beat_now   = we_reg ? c_wready : c_rvalid;
    // The c_done cycle may itself carry the final beat, so it is counted too.
    assign beat_total = beat_reg + {4'b0000, beat_now};
    assign beat_want  = {1'b0, len_reg} + 5'd1;
    assign in_grant   = (state_reg == GRANT);
    assign in_xfer    = (state_reg == XFER);
    assign own0_xfer  = in_xfer && !owner_reg;
    assign own1_xfer  = in_xfer && owner_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            owner_reg    <= 1'b0;
            addr_reg     <= '0;
            len_reg      <= '0;
            we_reg       <= 1'b0;
            c_req_reg    <= 1'b0;
            starve_reg   <= '0;
            beat_reg     <= '0;
            beat_err_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        owner_reg <= pick_m1;
                        addr_reg  <= pick_m1 ? m1_addr : m0_addr;
                        len_reg   <= pick_m1 ? m1_len : m0_len;
                        we_reg    <= pick_m1 && m1_we;
                        c_req_reg <= 1'b1;
                        state_reg <= GRANT;
                        if (!pick_m1) begin
                            starve_reg <= '0;
                        end else if (m0_req && !starved) begin
                            starve_reg <= starve_reg + SW'(1);
                        end
                    end
                end
                GRANT: begin
                    if (c_gnt) begin
                        c_req_reg <= 1'b0;
                        beat_reg  <= '0;
                        state_reg <= XFER;
                    end
                end
                XFER: begin
                    if (c_done) begin
                        if (beat_total != beat_want) begin
                            beat_err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                    end else begin
                        beat_reg <= beat_total;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    c_req_reg <= 1'b0;
                end
            endcase
        end
    end

    assign c_req    = c_req_reg;
    assign c_we     = we_reg;
    assign c_addr   = addr_reg;
    assign c_len    = len_reg;
    assign c_wdata  = m1_wdata;
    assign beat_err = beat_err_reg;

    // Controller handshakes reach only the current owner, and only in the matching state.
    assign m0_ack    = in_grant && !owner_reg && c_gnt;
    assign m0_rvalid = own0_xfer && c_rvalid;
    assign m0_rdata  = own0_xfer ? c_rdata : '0;
    assign m0_done   = own0_xfer && c_done;

    assign m1_ack    = in_grant && owner_reg && c_gnt;
    assign m1_wready = own1_xfer && we_reg && c_wready;
    assign m1_rvalid = own1_xfer && c_rvalid;
    assign m1_rdata  = own1_xfer ? c_rdata : '0;
    assign m1_done   = own1_xfer && c_done;

endmodule

// File: tb/tb_hram_arbiter.sv
// Directed bench for hram_arbiter: a transaction-level model checked every cycle,
// plus literal expectations for the arbitration order, beat counts and timing scenarios.
module tb_hram_arbiter;
    localparam int AW = 24;
    localparam int DW = 32;
    localparam int STARVE = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_req = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
    logic [AW-1:0] m0_addr = '0, m1_addr = '0;
    logic [3:0]    m0_len = '0, m1_len = '0;
    logic [DW-1:0] m1_wdata = '0;
    logic          m0_ack, m0_rvalid, m0_done;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic          m1_ack, m1_wready, m1_rvalid, m1_done;
    logic          c_req, c_we;
    logic [AW-1:0] c_addr;
    logic [3:0]    c_len;
    logic [DW-1:0] c_wdata;
    logic          c_gnt = 1'b0, c_wready = 1'b0, c_rvalid = 1'b0, c_done = 1'b0;
    logic [DW-1:0] c_rdata = '0;
    logic          beat_err;

    always #5 clk = ~clk;

    hram_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_len(m0_len),
        .m0_ack(m0_ack), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_len(m1_len), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_wready(m1_wready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .m1_done(m1_done),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_len(c_len), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_wready(c_wready), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .c_done(c_done),
        .beat_err(beat_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: one pending transaction record and a loss tally for m0.
    logic          md_open = 1'b0, md_gnt = 1'b0, md_owner = 1'b0, md_we = 1'b0, md_err = 1'b0;
    logic [AW-1:0] md_addr = '0;
    logic [3:0]    md_len = '0;
    int            md_beats = 0;
    int            md_losses = 0;
    logic          md_pick, md_beat, md_creq, md_xfer;

    assign md_pick = m1_req && !(m0_req && md_losses >= STARVE);
    assign md_beat = md_we ? c_wready : c_rvalid;
    assign md_creq = md_open && !md_gnt;
    assign md_xfer = md_open && md_gnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            md_open <= 1'b0; md_gnt <= 1'b0; md_owner <= 1'b0; md_we <= 1'b0; md_err <= 1'b0;
            md_addr <= '0; md_len <= '0; md_beats <= 0; md_losses <= 0;
        end else if (!md_open) begin
            if (m0_req || m1_req) begin
                md_open  <= 1'b1;
                md_gnt   <= 1'b0;
                md_owner <= md_pick;
                md_addr  <= md_pick ? m1_addr : m0_addr;
                md_len   <= md_pick ? m1_len : m0_len;
                md_we    <= md_pick && m1_we;
                if (!md_pick) md_losses <= 0;
                else if (m0_req) md_losses <= (md_losses + 1 > STARVE) ? STARVE : md_losses + 1;
            end
        end else if (!md_gnt) begin
            if (c_gnt) begin
                md_gnt   <= 1'b1;
                md_beats <= 0;
            end
        end else if (c_done) begin
            if (md_beats + int'(md_beat) != int'(md_len) + 1) md_err <= 1'b1;
            md_open <= 1'b0;
            md_gnt  <= 1'b0;
        end else begin
            md_beats <= md_beats + int'(md_beat);
        end
    end

    logic chk_en = 1'b0;
    int   grant_log[$];
    int   cnt_m0_ack = 0, cnt_m0_rv = 0, cnt_m0_done = 0;
    int   cnt_m1_done = 0, cnt_m1_wr = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("c_req", c_req, md_creq);
            chk("c_we", c_we, md_we);
            chk("c_addr", c_addr, md_addr);
            chk("c_len", c_len, md_len);
            chk("c_wdata", c_wdata, m1_wdata);
            chk("m0_ack", m0_ack, md_creq && !md_owner && c_gnt);
            chk("m1_ack", m1_ack, md_creq && md_owner && c_gnt);
            chk("m0_rvalid", m0_rvalid, md_xfer && !md_owner && c_rvalid);
            chk("m1_rvalid", m1_rvalid, md_xfer && md_owner && c_rvalid);
            chk("m1_wready", m1_wready, md_xfer && md_owner && md_we && c_wready);
            chk("m0_done", m0_done, md_xfer && !md_owner && c_done);
            chk("m1_done", m1_done, md_xfer && md_owner && c_done);
            chk("beat_err", beat_err, md_err);
            if (md_xfer && !md_owner && c_rvalid) chk("m0_rdata", m0_rdata, c_rdata);
            if (md_xfer && md_owner && c_rvalid) chk("m1_rdata", m1_rdata, c_rdata);
            if (m0_ack) grant_log.push_back(0);
            if (m1_ack) grant_log.push_back(1);
            cnt_m0_ack  += int'(m0_ack);
            cnt_m0_rv   += int'(m0_rvalid);
            cnt_m0_done += int'(m0_done);
            cnt_m1_done += int'(m1_done);
            cnt_m1_wr   += int'(m1_wready);
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Acts as the controller: waits for c_req, grants after gnt_delay cycles,
    // supplies nbeats beats, then c_done. Returns in the cycle after c_done.
    task automatic serve(input logic [AW-1:0] exp_addr, input logic exp_we, input int gnt_delay,
                         input int nbeats, input bit hold, input bit raise_m0, input int abort_beat);
        int   w = 0;
        logic a0, a1;
        while (!c_req && w < 20) begin
            tick;
            w++;
        end
        if (!c_req) begin
            chk("creq_timeout", 1'b0, 1'b1);
            return;
        end
        chk("grant_addr", c_addr, exp_addr);
        chk("grant_we", c_we, exp_we);
        repeat (gnt_delay) tick;
        c_gnt = 1'b1;
        #1;
        a0 = m0_ack;
        a1 = m1_ack;
        tick;
        c_gnt = 1'b0;
        if (!hold) begin
            if (a0) m0_req = 1'b0;
            if (a1) m1_req = 1'b0;
        end
        for (int k = 0; k < nbeats; k++) begin
            if (exp_we) begin
                c_wready = 1'b1;
                m1_wdata = 32'hA5A5_0001 + k;
                #1;
                chk("wdata_beat", c_wdata, 32'hA5A5_0001 + k);
            end else begin
                c_rvalid = 1'b1;
                c_rdata  = {8'hD0, exp_addr} + k;
            end
            if (k == abort_beat) begin
                rst = 1'b0;
                #1;
                chk("abort_rvalid", m0_rvalid, 1'b0);
                chk("abort_c_req", c_req, 1'b0);
                chk("abort_done", m0_done, 1'b0);
                chk("abort_ack", m0_ack, 1'b0);
                c_rvalid = 1'b0;
                return;
            end
            tick;
        end
        c_rvalid = 1'b0;
        c_wready = 1'b0;
        c_done   = 1'b1;
        if (raise_m0) m0_req = 1'b1;
        tick;
        c_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int s_ack, s_rv, s_done, l0, d1;
        int exp_order[8];
        exp_order = '{1, 1, 1, 0, 1, 1, 1, 0};

        tick;
        chk_en = 1'b1;
        tick;
        chk("rst_c_req", c_req, 1'b0);
        chk("rst_beat_err", beat_err, 1'b0);
        chk("rst_c_addr", c_addr, 24'h0);
        rst = 1'b1;
        tick;

        // m0 alone, 4-beat read, grant two cycles after c_req
        s_ack = cnt_m0_ack; s_rv = cnt_m0_rv; s_done = cnt_m0_done;
        m0_addr = 24'h001000; m0_len = 4'd3; m0_req = 1'b1;
        serve(24'h001000, 1'b0, 2, 4, 1'b0, 1'b0, -1);
        tick;
        chk("s1_ack_count", cnt_m0_ack - s_ack, 1);
        chk("s1_rvalid_count", cnt_m0_rv - s_rv, 4);
        chk("s1_done_count", cnt_m0_done - s_done, 1);
        chk("s1_beat_err", beat_err, 1'b0);

        // controller strobes while idle are ignored
        c_gnt = 1'b1; c_rvalid = 1'b1; c_done = 1'b1; c_wready = 1'b1;
        tick;
        c_gnt = 1'b0; c_rvalid = 1'b0; c_done = 1'b0; c_wready = 1'b0;
        tick;
        chk("idle_strobe_err", beat_err, 1'b0);
        chk("idle_strobe_creq", c_req, 1'b0);

        // both masters requesting continuously, single-beat reads
        l0 = grant_log.size();
        m0_addr = 24'h000200; m0_len = 4'd0;
        m1_addr = 24'h300000; m1_len = 4'd0; m1_we = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            serve(exp_order[i] == 1 ? 24'h300000 : 24'h000200, 1'b0, 0, 1, 1'b1, 1'b0, -1);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick;
        chk("s2_grant_total", grant_log.size() - l0, 8);
        for (int i = 0; i < 8; i++) begin
            if (l0 + i < grant_log.size()) chk("s2_grant_order", grant_log[l0 + i], exp_order[i]);
        end
        tick;

        // m1 two-beat write
        s_ack = cnt_m0_ack; s_rv = cnt_m0_rv; d1 = cnt_m1_wr;
        m1_addr = 24'h040000; m1_len = 4'd1; m1_we = 1'b1; m1_req = 1'b1;
        serve(24'h040000, 1'b1, 1, 2, 1'b0, 1'b0, -1);
        tick;
        chk("s3_wready_count", cnt_m1_wr - d1, 2);
        chk("s3_m0_quiet", (cnt_m0_ack - s_ack) + (cnt_m0_rv - s_rv), 0);
        chk("s3_beat_err", beat_err, 1'b0);

        // m1 read len=2 with only 2 beats -> sticky beat_err
        m1_addr = 24'h050000; m1_len = 4'd2; m1_we = 1'b0; m1_req = 1'b1;
        serve(24'h050000, 1'b0, 1, 2, 1'b0, 1'b0, -1);
        tick;
        chk("s4_beat_err_set", beat_err, 1'b1);
        m0_addr = 24'h000300; m0_len = 4'd0; m0_req = 1'b1;
        serve(24'h000300, 1'b0, 0, 1, 1'b0, 1'b0, -1);
        tick;
        chk("s4_beat_err_sticky", beat_err, 1'b1);

        // reset during the second beat of an 8-beat m0 read
        m0_addr = 24'h060000; m0_len = 4'd7; m0_req = 1'b1;
        serve(24'h060000, 1'b0, 1, 8, 1'b0, 1'b0, 1);
        m0_req = 1'b0;
        tick;
        tick;
        chk("s5_reset_err", beat_err, 1'b0);
        rst = 1'b1;
        tick;
        d1 = cnt_m1_done;
        m1_addr = 24'h061000; m1_len = 4'd0; m1_we = 1'b0; m1_req = 1'b1;
        serve(24'h061000, 1'b0, 1, 1, 1'b0, 1'b0, -1);
        tick;
        chk("s5_after_done", cnt_m1_done - d1, 1);
        chk("s5_after_err", beat_err, 1'b0);

        // m0 request rising in the c_done cycle of an m1 read
        m1_addr = 24'h070000; m1_len = 4'd0; m1_req = 1'b1;
        m0_addr = 24'h080000; m0_len = 4'd0;
        serve(24'h070000, 1'b0, 0, 1, 1'b0, 1'b1, -1);
        chk("s6_gap_idle", c_req, 1'b0);
        tick;
        chk("s6_gap_creq", c_req, 1'b1);
        chk("s6_gap_addr", c_addr, 24'h080000);
        serve(24'h080000, 1'b0, 0, 1, 1'b0, 1'b0, -1);
        tick;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
